// File: rtl/branch_history_predictor.sv
// Direction predictor with a pattern table of saturating counters, indexed either by PC (bimodal)
// or by PC XOR global history (gshare), plus zero-latency next-fetch PC computation.
module branch_history_predictor #(
   parameter int XLEN      = 64,
   parameter int ENTRIES   = 64,
   parameter int CTR_BITS  = 2,
   parameter int MODE      = 0,
   parameter int HIST_BITS = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] current_pc,
   input  logic [31:0]     next_instruction,
   input  logic            resolve_valid,
   input  logic [XLEN-1:0] resolve_pc,
   input  logic            resolve_taken,
   input  logic            resolve_mispredict,
   output logic            predict_taken,
   output logic [XLEN-1:0] predicted_pc,
   output logic [31:0]     mispredict_count
);

   localparam int IDX = $clog2(ENTRIES);
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   logic [CTR_BITS-1:0]  table_q [ENTRIES];
   logic [HIST_BITS-1:0] ghr_q, ghr_d;
   logic [31:0]          cnt_q, cnt_d;

   logic [IDX-1:0]      hist_mask;
   logic [IDX-1:0]      fetch_idx, upd_idx;
   logic [CTR_BITS-1:0] fetch_ctr, upd_old, ctr_d;
   logic [XLEN-1:0]     b_imm, j_imm, seq_pc, target;
   logic [6:0]          opcode;

   // Only the index bits of resolve_pc matter; the rest is deliberately dropped.
   logic unused_resolve_bits;
   assign unused_resolve_bits = ^{resolve_pc[XLEN-1:IDX+2], resolve_pc[1:0]};

   always_comb begin
      hist_mask = '0;
      if (MODE == 1) hist_mask[HIST_BITS-1:0] = ghr_q;
   end

   assign fetch_idx = current_pc[IDX+1:2] ^ hist_mask;
   assign upd_idx   = resolve_pc[IDX+1:2] ^ hist_mask;
   assign fetch_ctr = table_q[fetch_idx];
   assign upd_old   = table_q[upd_idx];

   assign opcode = next_instruction[6:0];
   assign b_imm  = {{(XLEN-13){next_instruction[31]}}, next_instruction[31], next_instruction[7],
                    next_instruction[30:25], next_instruction[11:8], 1'b0};
   assign j_imm  = {{(XLEN-21){next_instruction[31]}}, next_instruction[31], next_instruction[19:12],
                    next_instruction[20], next_instruction[30:21], 1'b0};
   assign seq_pc = current_pc + XLEN'(4);

   always_comb begin
      predict_taken = 1'b0;
      target        = seq_pc;
      if (opcode == OP_BRANCH) begin
         predict_taken = fetch_ctr[CTR_BITS-1];
         target        = current_pc + b_imm;
      end else if (opcode == OP_JAL) begin
         predict_taken = 1'b1;
         target        = current_pc + j_imm;
      end
   end

   assign predicted_pc     = predict_taken ? target : seq_pc;
   assign mispredict_count = cnt_q;

   always_comb begin
      ctr_d = upd_old;
      if (resolve_taken && upd_old != CTR_MAX)
         ctr_d = upd_old + 1'b1;
      else if (!resolve_taken && upd_old != '0)
         ctr_d = upd_old - 1'b1;
   end

   // Shift in the resolved direction; a shift-or also covers the single-bit history case.
   assign ghr_d = (ghr_q << 1) | HIST_BITS'(resolve_taken);

   assign cnt_d = (resolve_valid && resolve_mispredict && cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'd1 : cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_INIT;
      end else if (resolve_valid) begin
         table_q[upd_idx] <= ctr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ghr_q <= '0;
         cnt_q <= '0;
      end else begin
         if (MODE == 1 && resolve_valid) ghr_q <= ghr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: doc/branch_history_predictor.md
BRANCH_HISTORY_PREDICTOR -- requirements
Module: branch_history_predictor

Interface
REQ-001 Parameter XLEN, default 64, PC/address width in bits.
REQ-002 Parameter ENTRIES, default 64, number of pattern-table entries; power of two, minimum 4.
REQ-003 Parameter CTR_BITS, default 2, saturating-counter width; range 1..4.
REQ-004 Parameter MODE, default 0, index mode: 0 = bimodal (PC only), 1 = gshare (PC XOR global history).
REQ-005 Parameter HIST_BITS, default 6, global-history width; must be <= log2(ENTRIES); ignored when MODE=0.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 current_pc  input  XLEN  PC of the instruction in IF.
REQ-009 next_instruction  input  32  instruction word at current_pc.
REQ-010 resolve_valid  input  1  one-cycle pulse: a conditional branch has resolved; asserted only for opcode 1100011.
REQ-011 resolve_pc  input  XLEN  PC of the resolved branch.
REQ-012 resolve_taken  input  1  actual direction of the resolved branch.
REQ-013 resolve_mispredict  input  1  resolved branch was mispredicted; qualified by resolve_valid.
REQ-014 predict_taken  output  1  direction prediction for current_pc.
REQ-015 predicted_pc  output  XLEN  next fetch PC.
REQ-016 mispredict_count  output  32  saturating count of mispredicts since reset.

Function
REQ-017 IDX = log2(ENTRIES); PC index = pc[IDX+1:2].
REQ-018 Table index: MODE=0 -> PC index; MODE=1 -> PC index XOR {zero-extend, ghr[HIST_BITS-1:0]}.
REQ-019 Prediction path is combinational from current_pc, next_instruction, table and ghr; zero-cycle latency.
REQ-020 Conditional branch (opcode 1100011): predict_taken = MSB of the indexed counter; target = current_pc + sign-extended B-immediate {inst[31],inst[7],inst[30:25],inst[11:8],0}.
REQ-021 JAL (opcode 1101111): predict_taken = 1; target = current_pc + sign-extended J-immediate {inst[31],inst[19:12],inst[20],inst[30:21],0}; table is not read.
REQ-022 All other opcodes, including JALR: predict_taken = 0.
REQ-023 predicted_pc = predict_taken ? target : current_pc + 4; all additions modulo 2^XLEN (wrap, no overflow flag).
REQ-024 Update on rising edge when resolve_valid=1: entry at the table index of resolve_pc, computed with the pre-edge ghr, increments if resolve_taken and below 2^CTR_BITS-1, decrements if not taken and above 0; otherwise the entry holds.
REQ-025 MODE=1: on the same edge, ghr <= {ghr[HIST_BITS-2:0], resolve_taken}; with HIST_BITS=1, ghr <= resolve_taken. ghr is non-speculative.
REQ-026 Same-cycle read and update of the same entry: prediction uses the pre-edge value; no bypass.
REQ-027 Aliasing PCs share an entry; no tags.
REQ-028 mispredict_count increments on each edge with resolve_valid & resolve_mispredict; it holds at 0xFFFFFFFF.
REQ-029 resolve_mispredict with resolve_valid=0 is ignored.

Reset
REQ-030 While rst=1, asynchronously: every counter = 2^(CTR_BITS-1)-1 (weakly not-taken; 1 for CTR_BITS=2, 0 for CTR_BITS=1); ghr = 0; mispredict_count = 0.
REQ-031 An update pulse coincident with rst is discarded; reset asserted mid-run clears all state within the same cycle, and outputs reflect the reset state combinationally.
REQ-032 After rst deasserts, the first rising edge processes updates normally.

Verification
REQ-033 Defaults, after reset; pc=0x100, beq offset +16 -> predict_taken=0, predicted_pc=0x104.
REQ-034 Two resolves (pc=0x100, taken=1) -> counter 1->2->3; same beq -> predict_taken=1, predicted_pc=0x110; then four not-taken resolves -> counter 0, predicted_pc=0x104; a fifth leaves it at 0.
REQ-035 pc=0x200, JAL imm=-8 -> predicted_pc=0x1F8 regardless of table; pc=0x200 JALR -> 0x204; pc=0xFFFF_FFFF_FFFF_FFFC non-branch -> predicted_pc=0.
REQ-036 Aliasing: train 0x100 taken twice -> beq at 0x200 (same index 0) predicts taken.
REQ-037 MODE=1, HIST_BITS=2: resolves at 0x100 taken,taken -> ghr=2'b11; beq at 0x100 reads index 3, not 0; entry 3 = 1 -> predict_taken=0.
REQ-038 mispredict_count preset near max via 0xFFFFFFFF pulses -> holds; rst asserted asynchronously mid-clock -> count=0, counters=1, ghr=0 before the next edge.
